mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port valid_i  input  1  request valid.
REQ-005 SHALL have port ready_o  output  1  unit can accept a request.
REQ-006 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port a_i  input  XLEN  rs1 operand.
REQ-008 SHALL have port b_i  input  XLEN  rs2 operand.
REQ-009 SHALL have port flush_i  input  1  abort any in-flight operation.
REQ-010 SHALL have port valid_o  output  1  result valid.
REQ-011 SHALL have port ready_i  input  1  consumer takes result.
REQ-012 SHALL have port result_o  output  XLEN  result.
REQ-013 SHALL have port illegal_o  output  1  op not supported in this build, qualified by valid_o.
REQ-014 SHALL have port busy_o  output  1  state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 SHALL assert ready_o only in IDLE; accept when valid_i && ready_o at a rising edge; operands/funct3 registered at acceptance.
REQ-017 SHALL, on accept of a normal op, enter CALC, run exactly XLEN iterations (iteration counter 0..XLEN-1), then FIX one cycle, then DONE: valid_o high XLEN+2 cycles after accept edge.
REQ-018 SHALL multiply by radix-2 shift-add on operand magnitudes, 2*XLEN-bit product; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits with signedness per RISC-V.
REQ-019 SHALL divide by radix-2 restoring division on magnitudes; FIX applies signs: quotient negative iff operand signs differ, remainder takes dividend sign.
REQ-020 SHALL fast-path divide-by-zero (b_i==0): DIV/DIVU -> all ones, REM/REMU -> a_i; go directly IDLE -> DONE, valid_o one cycle after accept.
REQ-021 SHALL fast-path signed overflow (DIV/REM, a_i == most-negative, b_i == -1): DIV -> a_i, REM -> 0; same one-cycle latency.
REQ-022 SHALL hold result_o, illegal_o and valid_o stable in DONE while ready_i low; on valid_o && ready_i return to IDLE (ready_o high next cycle; no same-cycle re-accept).
REQ-023 SHALL, on flush_i high at any edge, return to IDLE, drop valid_o, discard result; flush_i takes priority over accept and over ready_i.
REQ-024 SHALL keep result_o at 0 and illegal_o at 0 whenever valid_o is low.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, valid_o 0, result_o 0, illegal_o 0, busy_o 0; ready_o 1 once rst_n is high.
REQ-026 SHALL discard any in-flight operation on reset mid-CALC; first post-reset accept behaves as from power-up.

Configuration
REQ-027 SHALL compile divider datapath only when macro MUL_DIV_UNIT_DIV_EN is defined.
REQ-028 SHALL, with MUL_DIV_UNIT_DIV_EN defined, support all eight ops per REQ-018..021.
REQ-029 SHALL, without MUL_DIV_UNIT_DIV_EN, accept funct3[2]==1 ops and return result_o 0 with illegal_o 1 in DONE one cycle after accept; multiply ops unaffected.

Verification (XLEN=32, MUL_DIV_UNIT_DIV_EN defined unless stated)
REQ-030 SHALL cover MUL a=7, b=0xFFFFFFFD -> result_o 0xFFFFFFEB, valid_o exactly 34 cycles after accept; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 SHALL cover DIV a=0xFFFFFFEC (-20), b=3 -> 0xFFFFFFFA; REM same operands -> 0xFFFFFFFE; DIVU 100/7 -> 14.
REQ-032 SHALL cover DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each valid one cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 SHALL cover backpressure: ready_i low 5 cycles in DONE -> result_o/valid_o unchanged, ready_o low; ready_i high -> IDLE next cycle.
REQ-034 SHALL cover flush_i at CALC iteration 10 and rst_n low at iteration 20 -> IDLE, valid_o never asserted, next MUL 3*4 -> 12.
REQ-035 SHALL cover build without MUL_DIV_UNIT_DIV_EN: DIV 9/3 -> result_o 0, illegal_o 1 one cycle after accept; MUL 3*4 -> 12, illegal_o 0.

Source files
------------

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative RV32M-style multiply/divide unit. Multiplication is radix-2
// shift-add on operand magnitudes. Division is radix-2 restoring division on
// magnitudes. Both run one bit per clock for XLEN clocks. A single FIX cycle
// afterwards applies the result signs and selects the requested half.
// Divide-by-zero and signed overflow bypass the iteration and complete
// directly from IDLE.
//
// Build option:
//   MUL_DIV_UNIT_DIV_EN  when defined, the divider datapath is compiled and
//                        all eight ops are supported. When undefined, divide
//                        ops (funct3[2]==1) complete one cycle after
//                        acceptance with result_o = 0 and illegal_o = 1.
//
// Parameters:
//   XLEN       operand/result width (8..64, even)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   valid_i    request valid
//   ready_o    unit can accept a request (high only in IDLE)
//   funct3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a_i        rs1 operand
//   b_i        rs2 operand
//   flush_i    abort any in-flight operation (highest priority)
//   valid_o    result valid
//   ready_i    consumer takes result
//   result_o   result, forced to 0 while valid_o is low
//   illegal_o  op not supported in this build, qualified by valid_o
//   busy_o     unit is not in IDLE
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

`ifdef MUL_DIV_UNIT_DIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

    // State and datapath registers
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    // Operand decode
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // Iteration and sign-fix datapath
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
`ifdef MUL_DIV_UNIT_DIV_EN
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
`endif

    // Signedness of each operand per op. MUL only needs the low half, so
    // treating it as unsigned gives the same bits. Magnitudes are taken here
    // so the iteration runs purely unsigned. The most-negative value maps
    // onto itself, which is the correct unsigned magnitude.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b001: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010: a_signed = 1'b1;
            3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            default: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
        endcase
        a_neg = a_signed & a_i[XLEN-1];
        b_neg = b_signed & b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    // {hi_q, lo_q} is the running product for multiply. The multiplier
    // starts in lo_q and its bits are consumed from the bottom as the product
    // shifts right. For divide, lo_q starts as the dividend. It shifts left
    // into the partial remainder hi_q and collects quotient bits from the
    // bottom. The restoring step compares hi_q:next-dividend-bit against
    // the divisor.
    always_comb begin
        mul_addend = lo_q[0] ? opb_q : '0;
        mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
        prod       = {hi_q, lo_q};
        prod_fix   = (neg_a_q ^ neg_b_q) ? -prod : prod;
`ifdef MUL_DIV_UNIT_DIV_EN
        div_diff   = {hi_q, lo_q[XLEN-1]} - {1'b0, opb_q};
        quo_fix    = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem_fix    = neg_a_q ? -hi_q : hi_q;
`endif
    end

    // Next-state logic. Flush overrides everything, including a pending
    // accept and a consumer handshake. result_q/illegal_q are written only on
    // entry to DONE and cleared on every exit, so they read as zero whenever
    // valid_o is low.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        illegal_d = illegal_q;

        if (flush_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            result_d  = '0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_d    = funct3;
                        neg_a_d = a_neg;
                        neg_b_d = b_neg;
                        cnt_d   = '0;
                        hi_d    = '0;
                        if (!funct3[2]) begin
                            opb_d   = a_mag;
                            lo_d    = b_mag;
                            state_d = CALC;
                        end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                            if (b_i == '0) begin
                                result_d = funct3[1] ? a_i : '1;
                                state_d  = DONE;
                            end else if (!funct3[0] && (a_i == MOST_NEG) && (b_i == '1)) begin
                                result_d = funct3[1] ? '0 : a_i;
                                state_d  = DONE;
                            end else begin
                                opb_d   = b_mag;
                                lo_d    = a_mag;
                                state_d = CALC;
                            end
`else
                            result_d  = '0;
                            illegal_d = 1'b1;
                            state_d   = DONE;
`endif
                        end
                    end
                end

                CALC: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (op_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            hi_d = div_diff[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
`else
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
`endif
                    if (cnt_q == LAST_ITER) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                FIX: begin
                    case (op_q)
                        3'b000:                 result_d = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
`ifdef MUL_DIV_UNIT_DIV_EN
                        3'b100, 3'b101:         result_d = quo_fix;
                        3'b110, 3'b111:         result_d = rem_fix;
`endif
                        default:                result_d = '0;
                    endcase
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end

                DONE: begin
                    if (ready_i) begin
                        result_d  = '0;
                        illegal_d = 1'b0;
                        state_d   = IDLE;
                    end
                end

                default: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    result_d  = '0;
                    illegal_d = 1'b0;
                end
            endcase
        end
    end

    // Register update. Reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign busy_o    = (state_q != IDLE);
    assign valid_o   = (state_q == DONE);
    assign result_o  = result_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit at XLEN=32. It runs directed cases for
// the documented corner values, then flush and reset aborts, then randomized
// ops. Randomized ops are checked against a plain-arithmetic reference model.
// The model follows MUL_DIV_UNIT_DIV_EN, so the bench matches whichever build
// it is compiled with.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            valid_i;
   logic            ready_o;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            flush_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;
   logic            illegal_o;
   logic            busy_o;

   int testsRun;
   int testsFailed;

   mul_div_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .funct3    (funct3),
      .a_i       (a_i),
      .b_i       (b_i),
      .flush_i   (flush_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .result_o  (result_o),
      .illegal_o (illegal_o),
      .busy_o    (busy_o)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck design can never hang the run
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: RISC-V M-extension semantics via 64-bit arithmetic
   function automatic void refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill, output int lat);
      longint          sa;
      longint          sb;
      longint          sp;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned up;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      r   = 32'd0;
      ill = 1'b0;
      lat = 34;
      case (f)
         3'b000: begin up = ua * ub;            r = up[31:0];  end
         3'b001: begin sp = sa * sb;            r = sp[63:32]; end
         3'b010: begin sp = sa * longint'(ub);  r = sp[63:32]; end
         3'b011: begin up = ua * ub;            r = up[63:32]; end
         default: begin
`ifdef MUL_DIV_UNIT_DIV_EN
            if (b == 32'd0) begin
               lat = 1;
               r   = f[1] ? a : 32'hFFFF_FFFF;
            end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lat = 1;
               r   = f[1] ? 32'd0 : a;
            end else begin
               case (f)
                  3'b100:  begin sp = sa / sb; r = sp[31:0]; end
                  3'b101:  begin up = ua / ub; r = up[31:0]; end
                  3'b110:  begin sp = sa % sb; r = sp[31:0]; end
                  default: begin up = ua % ub; r = up[31:0]; end
               endcase
            end
`else
            lat = 1;
            ill = 1'b1;
            r   = 32'd0;
`endif
         end
      endcase
   endfunction

   // Issue one op from a negedge with the unit idle, measure latency, hold
   // the result for 'hold' cycles of backpressure, then release it.
   task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input int hold,
                                input logic [31:0] expR, input logic expIll, input int expLat);
      int lat;
      funct3  = f;
      a_i     = a;
      b_i     = b;
      valid_i = 1'b1;
      ready_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      funct3  = 3'($urandom);
      a_i     = $urandom;
      b_i     = $urandom;
      lat = 1;
      while (!valid_o && lat < 100) begin
         checkOutput({tag, "/quiet"}, {31'd0, illegal_o, result_o}, 64'd0);
         checkOutput({tag, "/busy"}, {62'd0, busy_o, ready_o}, 64'd2);
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, "/latency"}, 64'(lat), 64'(expLat));
      checkOutput({tag, "/result"}, {32'd0, result_o}, {32'd0, expR});
      checkOutput({tag, "/illegal"}, {63'd0, illegal_o}, {63'd0, expIll});
      if (valid_o) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "/hold"}, {30'd0, valid_o, ready_o, result_o}, {30'd0, 2'b10, expR});
         end
         ready_i = 1'b1;
         @(negedge clk);
         ready_i = 1'b0;
         checkOutput({tag, "/release"}, {29'd0, valid_o, ready_o, busy_o, result_o}, {29'd0, 3'b010, 32'd0});
      end else begin
         flush_i = 1'b1;
         @(negedge clk);
         flush_i = 1'b0;
      end
   endtask

   // Directed case: expected values are the DIV_EN results; without the
   // divider every divide op completes in one cycle as illegal with result 0.
   task automatic directedOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input int hold, input logic [31:0] r, input int lat);
      logic [31:0] er;
      logic        ei;
      int          el;
      er = r;
      ei = 1'b0;
      el = lat;
`ifndef MUL_DIV_UNIT_DIV_EN
      if (f[2]) begin
         er = 32'd0;
         ei = 1'b1;
         el = 1;
      end
`endif
      applyStimulus(tag, f, a, b, hold, er, ei, el);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] rr;
      logic        ri;
      int          rl;
      logic [2:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        sawValid;

      testsRun    = 0;
      testsFailed = 0;
      rst_n   = 1'b0;
      valid_i = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b0;
      funct3  = 3'd0;
      a_i     = '0;
      b_i     = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_outputs", {29'd0, busy_o, valid_o, illegal_o, result_o}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_ready", {63'd0, ready_o}, 64'd1);

      // Directed corner values
      directedOp("mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, 34);
      directedOp("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 34);
      directedOp("mulh_neg",     3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 32'h0000_0000, 34);
      directedOp("mulhsu_neg",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 34);
      directedOp("div_m20_3",    3'b100, 32'hFFFF_FFEC,  32'd3,         0, 32'hFFFF_FFFA, 34);
      directedOp("rem_m20_3",    3'b110, 32'hFFFF_FFEC,  32'd3,         0, 32'hFFFF_FFFE, 34);
      directedOp("divu_100_7",   3'b101, 32'd100,        32'd7,         0, 32'd14,        34);
      directedOp("divu_by0",     3'b101, 32'd5,          32'd0,         0, 32'hFFFF_FFFF, 1);
      directedOp("rem_by0",      3'b110, 32'd5,          32'd0,         0, 32'd5,         1);
      directedOp("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'h8000_0000, 1);
      directedOp("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'd0,         1);
      directedOp("div_9_3",      3'b100, 32'd9,          32'd3,         0, 32'd3,         34);
      directedOp("backpressure", 3'b000, 32'd3,          32'd4,         5, 32'd12,        34);

      // Flush at CALC iteration 10
      funct3 = 3'b000; a_i = 32'd3; b_i = 32'd4; valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      checkOutput("flush_idle", {61'd0, busy_o, ready_o, valid_o}, 64'd2);
      sawValid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (valid_o) sawValid = 1'b1;
      end
      checkOutput("flush_no_valid", {63'd0, sawValid}, 64'd0);

      // Reset at CALC iteration 20
      funct3 = 3'b000; a_i = 32'd3; b_i = 32'd4; valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midcalc_reset", {29'd0, busy_o, valid_o, illegal_o, result_o}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_ready", {63'd0, ready_o}, 64'd1);
      sawValid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (valid_o) sawValid = 1'b1;
      end
      checkOutput("reset_no_valid", {63'd0, sawValid}, 64'd0);
      directedOp("mul_after_abort", 3'b000, 32'd3, 32'd4, 0, 32'd12, 34);

      // Randomized ops against the reference model
      for (int n = 0; n < 40; n++) begin
         rf = 3'($urandom_range(0, 7));
         ra = pickOperand();
         rb = pickOperand();
         refModel(rf, ra, rb, rr, ri, rl);
         applyStimulus($sformatf("rand%0d_f%0d", n, rf), rf, ra, rb, $urandom_range(0, 3), rr, ri, rl);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
